// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder: one GROUP-bit lookahead group is resolved per stage, valid/ready with global stall.
// Optional macro CLA_SUB_EN adds a 'sub' input that turns the operation into A - B - Cin.
module pipelined_cla_adder #(
   parameter int WIDTH = 16,
   parameter int GROUP = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
`ifdef CLA_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             Ovf
);

   localparam int NSTAGE = (GROUP < 1) ? 1 : WIDTH / GROUP;

   generate
      if (GROUP < 1) begin : g_bad_group
         $error("pipelined_cla_adder: GROUP must be at least 1");
      end else if ((WIDTH % GROUP) != 0) begin : g_bad_width
         $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP");
      end
   endgenerate

   // Group carries as flat sum-of-products of G/P terms, so no ripple chain is built inside a group.
   function automatic logic [GROUP:0] group_carries(input logic [GROUP-1:0] p,
                                                    input logic [GROUP-1:0] g,
                                                    input logic             cin);
      logic [GROUP:0] c;
      logic           term;
      c    = '0;
      c[0] = cin;
      for (int i = 0; i < GROUP; i++) begin
         term = cin;
         for (int j = 0; j <= i; j++) term = term & p[j];
         c[i+1] = term;
         for (int j = 0; j <= i; j++) begin
            term = g[j];
            for (int m = j + 1; m <= i; m++) term = term & p[m];
            c[i+1] = c[i+1] | term;
         end
      end
      return c;
   endfunction

   logic [NSTAGE-1:0] valid_q, valid_d;
   logic [NSTAGE-1:0] carry_q, carry_d;
   logic [WIDTH-1:0]  a_q   [NSTAGE];
   logic [WIDTH-1:0]  a_d   [NSTAGE];
   logic [WIDTH-1:0]  b_q   [NSTAGE];
   logic [WIDTH-1:0]  b_d   [NSTAGE];
   logic [WIDTH-1:0]  sum_q [NSTAGE];
   logic [WIDTH-1:0]  sum_d [NSTAGE];

   logic [GROUP-1:0]  grp_p   [NSTAGE];
   logic [GROUP:0]    grp_c   [NSTAGE];
   logic [WIDTH-1:0]  res_sum [NSTAGE];
   logic [NSTAGE-1:0] res_cout;
   logic [NSTAGE-1:0] res_cmsb;

   logic [WIDTH-1:0]  b_in;
   logic              c_in;
   logic              advance;

`ifdef CLA_SUB_EN
   assign b_in = B ^ {WIDTH{sub}};
   assign c_in = Cin ^ sub;
`else
   assign b_in = B;
   assign c_in = Cin;
`endif

   // Stage k resolves its own group k from its skewed operands and registered carry-in.
   always_comb begin
      res_cout = '0;
      res_cmsb = '0;
      for (int k = 0; k < NSTAGE; k++) begin
         grp_p[k]   = a_q[k][k*GROUP +: GROUP] ^ b_q[k][k*GROUP +: GROUP];
         grp_c[k]   = group_carries(grp_p[k],
                                    a_q[k][k*GROUP +: GROUP] & b_q[k][k*GROUP +: GROUP],
                                    carry_q[k]);
         res_sum[k] = sum_q[k];
         res_sum[k][k*GROUP +: GROUP] = grp_p[k] ^ grp_c[k][GROUP-1:0];
         res_cout[k] = grp_c[k][GROUP];
         res_cmsb[k] = grp_c[k][GROUP-1];
      end
   end

   assign advance  = ~valid_q[NSTAGE-1] | out_ready;
   assign in_ready = advance;

   // Whole pipeline shifts together or holds together; bubbles are carried as invalid stages.
   always_comb begin
      valid_d = valid_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      if (advance) begin
         valid_d[0] = in_valid;
         carry_d[0] = c_in;
         a_d[0]     = A;
         b_d[0]     = b_in;
         sum_d[0]   = '0;
         for (int k = 1; k < NSTAGE; k++) begin
            valid_d[k] = valid_q[k-1];
            carry_d[k] = res_cout[k-1];
            a_d[k]     = a_q[k-1];
            b_d[k]     = b_q[k-1];
            sum_d[k]   = res_sum[k-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         carry_q <= '0;
         for (int k = 0; k < NSTAGE; k++) begin
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            sum_q[k] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         carry_q <= carry_d;
         for (int k = 0; k < NSTAGE; k++) begin
            a_q[k]   <= a_d[k];
            b_q[k]   <= b_d[k];
            sum_q[k] <= sum_d[k];
         end
      end
   end

   assign out_valid = valid_q[NSTAGE-1];
   assign S         = res_sum[NSTAGE-1];
   assign Cout      = res_cout[NSTAGE-1];
   assign Ovf       = res_cmsb[NSTAGE-1] ^ res_cout[NSTAGE-1];

endmodule
